// File: rtl/lm07_sensor_emu.sv
// rtl/lm07_sensor_emu.sv - SPI responder emulating an LM07 temperature sensor
//
// Ports:
//   SYSCLK      in   system clock, all state on rising edge
//   RST         in   asynchronous active-high reset
//   CS          in   SPI chip select, active low, asynchronous
//   SCK         in   SPI clock, idles low, asynchronous
//   temp_in     in   [7:0] {sign, magnitude} to load
//   temp_load   in   one-cycle load strobe for temp_in
//   SIO         out  serial data, MSB first, updated after SCK falls
//   SIO_OE      out  tri-state enable, high while a frame is active
//   busy        out  high in LOAD and SHIFT
//   frame_done  out  one-cycle pulse at frame end
//   frame_short out  qualifies frame_done: LSB never presented
//   temp_reg    out  [7:0] stored temperature {sign, mag}

module lm07_sensor_emu #(
  parameter int          FRAME_BITS = 16,
  parameter logic [6:0]  MAX_MAG    = 7'd99,
  parameter logic [7:0]  RESET_TEMP = 8'h19,
  parameter logic [7:0]  TRAILER    = 8'h00,
  parameter logic        PAD_BIT    = 1'b0
) (
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic       CS,
  input  logic       SCK,
  input  logic [7:0] temp_in,
  input  logic       temp_load,
  output logic       SIO,
  output logic       SIO_OE,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_short,
  output logic [7:0] temp_reg
);

  localparam int         CW       = 5;
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LSB = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  cs_s1_q, cs_s2_q, cs_s3_q;
  logic                  cs_s1_d, cs_s2_d, cs_s3_d;
  logic                  sck_s1_q, sck_s2_q, sck_s3_q;
  logic                  sck_s1_d, sck_s2_d, sck_s3_d;
  logic [1:0]            warm_q, warm_d;
  logic                  armed_q, armed_d;
  logic                  pend_q, pend_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            temp_q, temp_d;

  logic                  cs_fall;
  logic                  sck_fall;
  logic [6:0]            load_mag;
  logic [15:0]           word_full;
  logic [FRAME_BITS-1:0] frame_word;

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_s3_q  <= 1'b1;
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      warm_q   <= 2'd0;
      armed_q  <= 1'b0;
      pend_q   <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      temp_q   <= RESET_TEMP;
    end else begin
      state_q  <= state_d;
      cs_s1_q  <= cs_s1_d;
      cs_s2_q  <= cs_s2_d;
      cs_s3_q  <= cs_s3_d;
      sck_s1_q <= sck_s1_d;
      sck_s2_q <= sck_s2_d;
      sck_s3_q <= sck_s3_d;
      warm_q   <= warm_d;
      armed_q  <= armed_d;
      pend_q   <= pend_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      temp_q   <= temp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    temp_d   = temp_q;

    cs_s1_d  = CS;
    cs_s2_d  = cs_s1_q;
    cs_s3_d  = cs_s2_q;
    sck_s1_d = SCK;
    sck_s2_d = sck_s1_q;
    sck_s3_d = sck_s2_q;

    // The synchronizer presets are not real samples of CS. warm_q counts
    // until cs_s2_q holds a genuine sample; only then may a high CS arm the
    // fall detector, so a frame already in progress at reset release is
    // rejected.
    warm_d   = warm_q[1] ? warm_q : warm_q + 2'd1;
    armed_d  = armed_q | (warm_q[1] & cs_s2_q);

    cs_fall  = armed_q & cs_s3_q & ~cs_s2_q;
    sck_fall = sck_s3_q & ~sck_s2_q;

    // A CS fall seen outside IDLE (e.g. in DONE) is held until IDLE takes it.
    pend_d   = pend_q | cs_fall;

    load_mag = (temp_in[6:0] > MAX_MAG) ? MAX_MAG : temp_in[6:0];
    if (temp_load) begin
      temp_d = {temp_in[7] & (load_mag != 7'd0), load_mag};
    end

    word_full  = {temp_q, TRAILER};
    frame_word = word_full[15 -: FRAME_BITS];

    unique case (state_q)
      IDLE: begin
        if (pend_q | cs_fall) begin
          // Capture from temp_q here so a load in this same cycle does not
          // leak into the frame.
          state_d = LOAD;
          pend_d  = 1'b0;
          shift_d = frame_word;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        // Exit on synced CS level rather than only the edge so a rise that
        // lands during LOAD cannot strand the FSM in SHIFT.
        if (cs_s2_q) begin
          state_d = DONE;
        end else if (sck_fall) begin
          shift_d = shift_q << 1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == LOAD) || (state_q == SHIFT);
  assign SIO_OE      = busy;
  assign SIO         = busy & ((cnt_q == CNT_MAX) ? PAD_BIT : shift_q[FRAME_BITS-1]);
  assign frame_done  = (state_q == DONE);
  assign frame_short = (state_q == DONE) && (cnt_q < CNT_LSB);
  assign temp_reg    = temp_q;

endmodule

// File: tb/tb_lm07_sensor_emu.sv
// tb/tb_lm07_sensor_emu.sv - self-checking bench for lm07_sensor_emu

module tb_lm07_sensor_emu;

  logic       SYSCLK = 1'b0;
  logic       RST = 1'b1;
  logic       CS = 1'b1;
  logic       SCK = 1'b0;
  logic [7:0] temp_in = 8'h00;
  logic       temp_load = 1'b0;
  logic       SIO;
  logic       SIO_OE;
  logic       busy;
  logic       frame_done;
  logic       frame_short;
  logic [7:0] temp_reg;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_temp;

  lm07_sensor_emu dut (
    .SYSCLK      (SYSCLK),
    .RST         (RST),
    .CS          (CS),
    .SCK         (SCK),
    .temp_in     (temp_in),
    .temp_load   (temp_load),
    .SIO         (SIO),
    .SIO_OE      (SIO_OE),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_short (frame_short),
    .temp_reg    (temp_reg)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_load(input logic [7:0] v);
    int mag;
    mag = int'(v[6:0]);
    if (mag > 99) mag = 99;
    return {(v[7] && mag != 0), 7'(mag)};
  endfunction

  function automatic logic [31:0] ref_bits(input logic [7:0] t, input int n);
    logic [15:0] w;
    logic [31:0] e;
    w = {t, 8'h00};
    e = '0;
    for (int i = 0; i < n; i++) begin
      e = {e[30:0], (i < 16) ? w[15 - i] : 1'b0};
    end
    return e;
  endfunction

  task automatic do_load(input logic [7:0] v);
    temp_in   = v;
    temp_load = 1'b1;
    @(negedge SYSCLK);
    temp_load = 1'b0;
  endtask

  // SIO is sampled just before each SCK rise, as the initiator would.
  task automatic run_frame(input string tag, input int n, input int load_at,
                           input logic [7:0] load_val, input logic [7:0] exp_temp,
                           input logic exp_short);
    logic [31:0] got;
    int          oe_low;
    int          done_cnt;
    logic        short_seen;
    got        = '0;
    oe_low     = 0;
    done_cnt   = 0;
    short_seen = 1'b0;
    CS = 1'b0;
    repeat (6) @(negedge SYSCLK);
    for (int i = 0; i < n; i++) begin
      got = {got[30:0], SIO};
      if (SIO_OE !== 1'b1) oe_low++;
      SCK = 1'b1;
      repeat (6) @(negedge SYSCLK);
      SCK = 1'b0;
      if (i + 1 == load_at) begin
        do_load(load_val);
        repeat (5) @(negedge SYSCLK);
      end else begin
        repeat (6) @(negedge SYSCLK);
      end
    end
    CS = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge SYSCLK);
      if (frame_done === 1'b1) begin
        done_cnt++;
        short_seen = frame_short;
      end
    end
    check({tag, "_bits"}, got, ref_bits(exp_temp, n));
    check({tag, "_oe_during"}, 32'(oe_low), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_short"}, {31'd0, short_seen}, {31'd0, exp_short});
    check({tag, "_oe_after"}, {31'd0, SIO_OE}, 32'd0);
    repeat (4) @(negedge SYSCLK);
  endtask

  initial begin
    int          oe_hi;
    int          done_cnt;
    logic [7:0]  v;
    int          n;

    repeat (3) @(negedge SYSCLK);
    check("rst_sio_oe_in_reset", {31'd0, SIO_OE}, 32'd0);
    RST = 1'b0;
    @(negedge SYSCLK);
    m_temp = 8'h19;
    check("rst_temp_reg", {24'd0, temp_reg}, {24'd0, m_temp});
    check("rst_sio", {31'd0, SIO}, 32'd0);
    check("rst_sio_oe", {31'd0, SIO_OE}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_short", {31'd0, frame_short}, 32'd0);
    repeat (6) @(negedge SYSCLK);

    run_frame("reset_val", 16, -1, 8'h00, m_temp, 1'b0);

    do_load(8'h7F);
    m_temp = ref_load(8'h7F);
    check("sat_temp_reg", {24'd0, temp_reg}, {24'd0, m_temp});
    run_frame("sat", 16, -1, 8'h00, m_temp, 1'b0);

    do_load(8'h80);
    m_temp = ref_load(8'h80);
    check("negzero_temp_reg", {24'd0, temp_reg}, {24'd0, m_temp});
    run_frame("negzero", 16, -1, 8'h00, m_temp, 1'b0);

    run_frame("midload_old", 16, 3, 8'h8A, m_temp, 1'b0);
    m_temp = ref_load(8'h8A);
    check("midload_temp_reg", {24'd0, temp_reg}, {24'd0, m_temp});
    run_frame("midload_new", 16, -1, 8'h00, m_temp, 1'b0);

    run_frame("short", 5, -1, 8'h00, m_temp, 1'b1);
    run_frame("after_short", 16, -1, 8'h00, m_temp, 1'b0);

    run_frame("overlong", 20, -1, 8'h00, m_temp, 1'b0);

    // Reset in the middle of bit 6, CS held low across release.
    CS = 1'b0;
    repeat (6) @(negedge SYSCLK);
    for (int i = 0; i < 5; i++) begin
      SCK = 1'b1;
      repeat (6) @(negedge SYSCLK);
      SCK = 1'b0;
      repeat (6) @(negedge SYSCLK);
    end
    SCK = 1'b1;
    repeat (2) @(negedge SYSCLK);
    RST = 1'b1;
    SCK = 1'b0;
    repeat (2) @(negedge SYSCLK);
    RST = 1'b0;
    m_temp = 8'h19;
    oe_hi = 0;
    for (int i = 0; i < 4; i++) begin
      repeat (6) @(negedge SYSCLK);
      if (SIO_OE !== 1'b0) oe_hi++;
      SCK = 1'b1;
      repeat (6) @(negedge SYSCLK);
      if (SIO_OE !== 1'b0) oe_hi++;
      SCK = 1'b0;
    end
    check("midrst_oe_low", 32'(oe_hi), 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    CS = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge SYSCLK);
      if (frame_done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_temp_reg", {24'd0, temp_reg}, {24'd0, m_temp});
    run_frame("midrst_next", 16, -1, 8'h00, m_temp, 1'b0);

    for (int k = 0; k < 8; k++) begin
      v = 8'($urandom);
      n = $urandom_range(8, 20);
      do_load(v);
      m_temp = ref_load(v);
      check($sformatf("rand%0d_temp_reg", k), {24'd0, temp_reg}, {24'd0, m_temp});
      run_frame($sformatf("rand%0d", k), n, -1, 8'h00, m_temp, (n < 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
